// File: rtl/perceptron_trainer.sv
// Online trainer for the 4-class shape perceptron: scores a labelled sample, then applies the perceptron rule on a mistake.
// Optional mistake counter is built only when PTRAIN_MISTAKE_CNT_EN is defined.
module perceptron_trainer #(
    parameter int WEIGHT_W = 6,
    parameter int LR       = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sample_valid,
    output logic                       sample_ready,
    input  logic [2:0]                 edges,
    input  logic [3:0]                 curves,
    input  logic [1:0]                 target,
    input  logic                       train_en,
    output logic                       result_valid,
    output logic [3:0]                 pred_onehot,
    output logic                       mistake,
    input  logic [1:0]                 rd_class,
    input  logic [2:0]                 rd_idx,
    output logic signed [WEIGHT_W-1:0] rd_data,
    output logic [7:0]                 mistake_cnt
);

    // state  | meaning
    // IDLE   | ready for a sample
    // SCORE  | 8 cycles, idx 0..7 accumulating w[c][idx] for set features and bias
    // ARGMAX | register the winning class (ties to lowest index)
    // UPDATE | result pulse; weight update on a trained mistake
    typedef enum logic [1:0] {IDLE, SCORE, ARGMAX, UPDATE} state_t;

    localparam int ACC_W = WEIGHT_W + 3;
    localparam int SUM_W = WEIGHT_W + 2;
    localparam logic signed [SUM_W-1:0] S_MAX = SUM_W'(2**(WEIGHT_W-1) - 1);
    localparam logic signed [SUM_W-1:0] S_MIN = SUM_W'(-(2**(WEIGHT_W-1)));
    localparam logic signed [SUM_W-1:0] LR_S  = SUM_W'(LR);

    state_t                     state, state_nx;
    logic [2:0]                 idx;
    logic [7:0]                 feat_q;
    logic [1:0]                 target_q;
    logic [1:0]                 pred_q;
    logic                       train_en_q;
    logic [1:0]                 best;
    logic                       accept;
    logic                       do_update;
    logic signed [WEIGHT_W-1:0] w   [4][8];
    logic signed [ACC_W-1:0]    acc [4];

    function automatic logic signed [WEIGHT_W-1:0] sat_add(
        input logic signed [WEIGHT_W-1:0] a,
        input logic signed [SUM_W-1:0]    d
    );
        logic signed [SUM_W-1:0] s;
        s = $signed({{2{a[WEIGHT_W-1]}}, a}) + d;
        if (s > S_MAX)
            return S_MAX[WEIGHT_W-1:0];
        else if (s < S_MIN)
            return S_MIN[WEIGHT_W-1:0];
        else
            return s[WEIGHT_W-1:0];
    endfunction

    assign accept    = sample_valid && sample_ready;
    assign do_update = (state == UPDATE) && mistake && train_en_q;
    assign rd_data   = w[rd_class][rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = SCORE;
            SCORE:   if (idx == 3'd7) state_nx = ARGMAX;
            ARGMAX:  state_nx = UPDATE;
            UPDATE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        sample_ready = (state == IDLE);
        result_valid = (state == UPDATE);
    end

    always_comb begin
        best = 2'd0;
        for (int c = 1; c < 4; c++) begin
            if (acc[c] > acc[best])
                best = 2'(c);
        end
    end

    // Bit 7 of feat_q is the bias term, which always contributes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feat_q      <= '0;
            target_q    <= '0;
            train_en_q  <= 1'b0;
            idx         <= '0;
            pred_q      <= '0;
            pred_onehot <= '0;
            mistake     <= 1'b0;
            for (int c = 0; c < 4; c++)
                acc[c] <= '0;
        end else begin
            if (accept) begin
                feat_q     <= {1'b1, curves, edges};
                target_q   <= target;
                train_en_q <= train_en;
                idx        <= '0;
                for (int c = 0; c < 4; c++)
                    acc[c] <= '0;
            end else if (state == SCORE) begin
                for (int c = 0; c < 4; c++) begin
                    if (feat_q[idx])
                        acc[c] <= acc[c] + $signed({{3{w[c][idx][WEIGHT_W-1]}}, w[c][idx]});
                end
                idx <= idx + 3'd1;
            end
            if (state == ARGMAX) begin
                pred_q      <= best;
                pred_onehot <= 4'b0001 << best;
                mistake     <= (best != target_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 4; c++)
                for (int i = 0; i < 8; i++)
                    w[c][i] <= '0;
        end else if (do_update) begin
            for (int c = 0; c < 4; c++) begin
                for (int i = 0; i < 8; i++) begin
                    if (feat_q[i]) begin
                        if (2'(c) == target_q)
                            w[c][i] <= sat_add(w[c][i], LR_S);
                        else if (2'(c) == pred_q)
                            w[c][i] <= sat_add(w[c][i], -LR_S);
                    end
                end
            end
        end
    end

`ifdef PTRAIN_MISTAKE_CNT_EN
    logic [7:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if ((state == UPDATE) && mistake && (cnt_q != 8'hFF))
            cnt_q <= cnt_q + 8'd1;
    end

    assign mistake_cnt = cnt_q;
`else
    assign mistake_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_perceptron_trainer.sv
// Directed self-checking bench for perceptron_trainer: a LR=1 unit for the main sequence and
// a LR=31 unit that drives weights into both saturation limits.
module tb_perceptron_trainer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m_valid = 1'b0;
    logic       s_valid = 1'b0;
    logic [2:0] edges = '0;
    logic [3:0] curves = '0;
    logic [1:0] target = '0;
    logic       train_en = 1'b0;
    logic [1:0] rd_class = '0;
    logic [2:0] rd_idx = '0;

    logic              m_ready, m_rv, m_mis;
    logic [3:0]        m_oh;
    logic signed [5:0] m_rd;
    logic [7:0]        m_cnt;
    logic              s_ready, s_rv, s_mis;
    logic [3:0]        s_oh;
    logic signed [5:0] s_rd;
    logic [7:0]        s_cnt;

    int checks = 0;
    int errors = 0;
    int exp_w [4][8];

    perceptron_trainer #(.WEIGHT_W(6), .LR(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .sample_valid(m_valid), .sample_ready(m_ready),
        .edges(edges), .curves(curves), .target(target), .train_en(train_en),
        .result_valid(m_rv), .pred_onehot(m_oh), .mistake(m_mis),
        .rd_class(rd_class), .rd_idx(rd_idx), .rd_data(m_rd), .mistake_cnt(m_cnt)
    );

    perceptron_trainer #(.WEIGHT_W(6), .LR(31)) u_sat (
        .clk(clk), .rst_n(rst_n), .sample_valid(s_valid), .sample_ready(s_ready),
        .edges(edges), .curves(curves), .target(target), .train_en(train_en),
        .result_valid(s_rv), .pred_onehot(s_oh), .mistake(s_mis),
        .rd_class(rd_class), .rd_idx(rd_idx), .rd_data(s_rd), .mistake_cnt(s_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int cnt_exp(input int n);
`ifdef PTRAIN_MISTAKE_CNT_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_exp();
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 8; i++)
                exp_w[c][i] = 0;
    endtask

    task automatic check_weights(input bit sat, input string tag);
        logic signed [5:0] v;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 8; i++) begin
                rd_class = 2'(c);
                rd_idx   = 3'(i);
                #1;
                v = sat ? s_rd : m_rd;
                chk($sformatf("%s_w%0d_%0d", tag, c, i), v, exp_w[c][i]);
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_sample(input bit sat, input logic [2:0] e, input logic [3:0] c,
                              input logic [1:0] t, input bit te,
                              input logic [3:0] exp_oh, input bit exp_mis, input string tag);
        int waitc, rv_at, rv_n, rdy_n;
        logic [3:0] oh_cap;
        logic mis_cap;
        waitc = 0;
        oh_cap = 'x;
        mis_cap = 1'bx;
        @(negedge clk);
        while (!(sat ? s_ready : m_ready) && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        chk({tag, "_ready"}, sat ? s_ready : m_ready, 1);
        edges = e; curves = c; target = t; train_en = te;
        if (sat) s_valid = 1'b1; else m_valid = 1'b1;
        @(posedge clk);
        #1;
        m_valid = 1'b0; s_valid = 1'b0;
        edges = ~e; curves = ~c; target = ~t; train_en = ~te;
        rv_at = 0; rv_n = 0; rdy_n = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (sat ? s_rv : m_rv) begin
                rv_n++;
                rv_at = k;
                oh_cap = sat ? s_oh : m_oh;
                mis_cap = sat ? s_mis : m_mis;
            end
            if (k <= 10 && (sat ? s_ready : m_ready)) rdy_n++;
        end
        chk({tag, "_rv_cycle"}, rv_at, 10);
        chk({tag, "_rv_count"}, rv_n, 1);
        chk({tag, "_busy_ready"}, rdy_n, 0);
        chk({tag, "_onehot"}, oh_cap, exp_oh);
        chk({tag, "_mistake"}, mis_cap, exp_mis);
        chk({tag, "_onehot_hold"}, sat ? s_oh : m_oh, exp_oh);
    endtask

    initial begin
        int first_acc, second_acc, acc_n, rv_n, rdy_lo;

        do_reset();
        chk("rst_ready", m_ready, 1);
        chk("rst_rv", m_rv, 0);
        chk("rst_onehot", m_oh, 0);
        chk("rst_mistake", m_mis, 0);
        chk("rst_cnt", m_cnt, 0);
        clear_exp();
        check_weights(0, "rst");

        run_sample(0, 3'b101, 4'b0000, 2'd2, 1'b1, 4'b0001, 1'b1, "first");
        exp_w[2][0] = 1; exp_w[2][2] = 1; exp_w[2][7] = 1;
        exp_w[0][0] = -1; exp_w[0][2] = -1; exp_w[0][7] = -1;
        check_weights(0, "first");
        chk("first_cnt", m_cnt, cnt_exp(1));

        run_sample(0, 3'b101, 4'b0000, 2'd2, 1'b1, 4'b0100, 1'b0, "repeat");
        check_weights(0, "repeat");
        chk("repeat_cnt", m_cnt, cnt_exp(1));

        run_sample(0, 3'b000, 4'b0001, 2'd1, 1'b0, 4'b0100, 1'b1, "infer");
        check_weights(0, "infer");
        chk("infer_cnt", m_cnt, cnt_exp(2));

        run_sample(0, 3'b000, 4'b1000, 2'd3, 1'b1, 4'b0100, 1'b1, "curve");
        exp_w[3][6] = 1; exp_w[3][7] = 1; exp_w[2][6] = -1; exp_w[2][7] = 0;
        check_weights(0, "curve");
        chk("curve_cnt", m_cnt, cnt_exp(3));

        // Alternating targets on identical features settle into a two-sample cycle.
        do_reset();
        for (int p = 0; p < 40; p++) begin
            run_sample(0, 3'b010, 4'b0000, 2'd3, 1'b1, (p == 0) ? 4'b0001 : 4'b0010, 1'b1, "pair_a");
            run_sample(0, 3'b010, 4'b0000, 2'd1, 1'b1, 4'b1000, 1'b1, "pair_b");
        end
        clear_exp();
        exp_w[0][1] = -1; exp_w[0][7] = -1; exp_w[1][1] = 1; exp_w[1][7] = 1;
        check_weights(0, "pair");
        chk("pair_cnt", m_cnt, cnt_exp(80));

        @(negedge clk);
        edges = 3'b000; curves = 4'b0000; target = 2'd0; train_en = 1'b0;
        m_valid = 1'b1;
        first_acc = -1; second_acc = -1; acc_n = 0;
        for (int i = 0; i < 33; i++) begin
            if (m_ready) begin
                acc_n++;
                if (first_acc < 0) first_acc = i;
                else if (second_acc < 0) second_acc = i;
            end
            @(negedge clk);
        end
        m_valid = 1'b0;
        chk("busy_accepts", acc_n, 3);
        chk("busy_spacing", second_acc - first_acc, 11);
        repeat (2) @(negedge clk);
        check_weights(0, "busy");
        chk("busy_cnt", m_cnt, cnt_exp(83));

        @(negedge clk);
        edges = 3'b111; curves = 4'b1111; target = 2'd3; train_en = 1'b1;
        m_valid = 1'b1;
        @(posedge clk);
        #1;
        m_valid = 1'b0;
        rv_n = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (m_rv) rv_n++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        rd_class = 2'd0; rd_idx = 3'd7;
        #1;
        chk("abort_async_clear", m_rd, 0);
        repeat (2) begin
            @(negedge clk);
            if (m_rv) rv_n++;
        end
        rst_n = 1'b1;
        rdy_lo = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (m_rv) rv_n++;
            if (!m_ready) rdy_lo++;
        end
        chk("abort_no_result", rv_n, 0);
        chk("abort_ready", rdy_lo, 0);
        chk("abort_cnt", m_cnt, 0);
        clear_exp();
        check_weights(0, "abort");

        run_sample(1, 3'b000, 4'b0000, 2'd1, 1'b1, 4'b0001, 1'b1, "sat1");
        run_sample(1, 3'b001, 4'b0000, 2'd0, 1'b1, 4'b0010, 1'b1, "sat2");
        run_sample(1, 3'b000, 4'b0000, 2'd1, 1'b1, 4'b0001, 1'b1, "sat3");
        run_sample(1, 3'b001, 4'b0000, 2'd2, 1'b1, 4'b0001, 1'b1, "sat4");
        run_sample(1, 3'b000, 4'b0000, 2'd2, 1'b1, 4'b0010, 1'b1, "sat5");
        clear_exp();
        exp_w[0][7] = -32;
        exp_w[1][0] = -31;
        exp_w[2][0] = 31; exp_w[2][7] = 31;
        check_weights(1, "sat");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
